// File: rtl/jtag_1149_d10_mstr_tx_pkt_gen_if.sv
// Scan request handshake between the master instruction source and the
// Tx packet generator.
interface jtag_1149_d10_mstr_tx_pkt_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SCAN_WIDTH = 32
);
  logic [SCAN_WIDTH-1:0] scan_req_data;
  logic [3:0]            scan_req_be;
  logic [DATA_WIDTH-1:0] scan_req_type;
  logic                  scan_req_vld;
  logic                  scan_req_rdy;

  modport master (
    output scan_req_data, scan_req_be, scan_req_type, scan_req_vld,
    input  scan_req_rdy
  );

  modport slave (
    input  scan_req_data, scan_req_be, scan_req_type, scan_req_vld,
    output scan_req_rdy
  );
endinterface

// File: rtl/jtag_1149_d10_mstr_tx_pkt_gen.sv
// Master-side PEDDA Tx packet generator: frames one scan request as
// SOP/type/payload/CRC/EOP and holds it until the Rx side resolves it.
module jtag_1149_d10_mstr_tx_pkt_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int SCAN_WIDTH  = 32,
  parameter int CRC_WIDTH   = 32,
  parameter int IDLE_GAP    = 4,
  parameter int MAX_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  jtag_1149_d10_mstr_tx_pkt_gen_if.slave scan_req,
  output logic [DATA_WIDTH-1:0] encoder_data,
  output logic                  encoder_k_in,
  output logic                  crc_data_valid,
  output logic [3:0]            crc_data_be,
  output logic                  crc_data_eop,
  output logic [CRC_WIDTH-1:0]  crc_data_in,
  input  logic [CRC_WIDTH-1:0]  crc_result,
  output logic                  send_pkt,
  output logic [DATA_WIDTH-1:0] send_pkt_type,
  input  logic                  rd_nxt_instr,
  input  logic                  instr_retry,
  input  logic                  suspend_xmission,
  input  logic                  unrecoverable_error,
  input  logic                  scan_rsp_time_out,
  output logic                  tx_abort,
  output logic                  tx_timeout_error
);
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SOP      = 4'd1;
  localparam logic [3:0] ST_TYPE     = 4'd2;
  localparam logic [3:0] ST_PAYLOAD  = 4'd3;
  localparam logic [3:0] ST_CRC      = 4'd4;
  localparam logic [3:0] ST_EOP      = 4'd5;
  localparam logic [3:0] ST_GAP      = 4'd6;
  localparam logic [3:0] ST_WAIT_RSP = 4'd7;
  localparam logic [3:0] ST_RESEND   = 4'd8;

  localparam int TO_W = (MAX_TIMEOUT < 1) ? 1 : $clog2(MAX_TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] K_SOP  = DATA_WIDTH'(8'h3C);
  localparam logic [DATA_WIDTH-1:0] K_EOP  = DATA_WIDTH'(8'hFD);
  localparam logic [DATA_WIDTH-1:0] K_IDLE = DATA_WIDTH'(8'hBC);

  logic [3:0]            state;
  logic [3:0]            cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  drop;
  logic [SCAN_WIDTH-1:0] buf_data;
  logic [3:0]            buf_be;
  logic [DATA_WIDTH-1:0] buf_type;
  logic [2:0]            buf_len;
  logic [CRC_WIDTH-1:0]  crc_q;
  logic [DATA_WIDTH-1:0] char_d;
  logic                  k_d;
  logic [2:0]            req_len;
  logic [4:0]            byte_ofs;
  logic                  handshake;
  logic                  uerr_take;
  logic                  eop_sent;

  assign scan_req.scan_req_rdy = (state == ST_IDLE) && !suspend_xmission && !rst;
  assign handshake = scan_req.scan_req_vld && scan_req.scan_req_rdy;
  // drop guards against a second abort pulse while a truncated packet drains
  assign uerr_take = unrecoverable_error && (state != ST_IDLE) && !drop;
  assign eop_sent  = (state == ST_EOP) && !drop && !uerr_take;

  assign crc_data_valid = (state == ST_SOP);
  assign crc_data_eop   = (state == ST_SOP);
  assign crc_data_be    = (state == ST_SOP) ? buf_be : 4'd0;
  assign crc_data_in    = (state == ST_SOP) ? CRC_WIDTH'(buf_data) : '0;

  always_comb begin
    req_len = 3'd0;
    if (scan_req.scan_req_be[3])      req_len = 3'd4;
    else if (scan_req.scan_req_be[2]) req_len = 3'd3;
    else if (scan_req.scan_req_be[1]) req_len = 3'd2;
    else if (scan_req.scan_req_be[0]) req_len = 3'd1;
  end

  always_comb begin
    byte_ofs = {cnt[1:0], 3'b000};
    char_d   = K_IDLE;
    k_d      = 1'b1;
    case (state)
      ST_SOP:     char_d = K_SOP;
      ST_TYPE:    begin char_d = buf_type; k_d = 1'b0; end
      ST_PAYLOAD: begin char_d = buf_data[byte_ofs +: DATA_WIDTH]; k_d = 1'b0; end
      ST_CRC:     begin char_d = crc_q[byte_ofs +: DATA_WIDTH]; k_d = 1'b0; end
      ST_EOP:     char_d = K_EOP;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= 4'd0;
      to_cnt           <= '0;
      drop             <= 1'b0;
      buf_data         <= '0;
      buf_be           <= 4'd0;
      buf_type         <= '0;
      buf_len          <= 3'd0;
      crc_q            <= '0;
      encoder_data     <= K_IDLE;
      encoder_k_in     <= 1'b1;
      send_pkt         <= 1'b0;
      send_pkt_type    <= '0;
      tx_abort         <= 1'b0;
      tx_timeout_error <= 1'b0;
    end else begin
      encoder_data <= char_d;
      encoder_k_in <= k_d;
      send_pkt     <= eop_sent;
      tx_abort     <= 1'b0;
      if (eop_sent) send_pkt_type <= buf_type;

      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          if (handshake) begin
            buf_data         <= scan_req.scan_req_data;
            buf_be           <= scan_req.scan_req_be;
            buf_type         <= scan_req.scan_req_type;
            buf_len          <= req_len;
            to_cnt           <= '0;
            tx_timeout_error <= 1'b0;
            state            <= ST_SOP;
          end
        end
        ST_SOP: state <= ST_TYPE;
        ST_TYPE: begin
          crc_q <= crc_result;
          cnt   <= 4'd0;
          state <= (buf_len != 3'd0) ? ST_PAYLOAD : ST_CRC;
        end
        ST_PAYLOAD: begin
          if (cnt == {1'b0, buf_len - 3'd1}) begin
            cnt   <= 4'd0;
            state <= ST_CRC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CRC: begin
          if (cnt == 4'd3) state <= ST_EOP;
          else             cnt   <= cnt + 4'd1;
        end
        ST_EOP: begin
          cnt   <= 4'd0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == 4'(IDLE_GAP - 1))
            state <= (drop || unrecoverable_error) ? ST_IDLE : ST_WAIT_RSP;
          else
            cnt <= cnt + 4'd1;
        end
        ST_WAIT_RSP: begin
          if (rd_nxt_instr) begin
            state <= ST_IDLE;
          end else if (instr_retry) begin
            state <= ST_RESEND;
          end else if (scan_rsp_time_out) begin
            if (to_cnt < TO_W'(MAX_TIMEOUT)) begin
              to_cnt <= to_cnt + TO_W'(1);
              state  <= ST_RESEND;
            end else begin
              tx_timeout_error <= 1'b1;
              tx_abort         <= 1'b1;
              state            <= ST_IDLE;
            end
          end
        end
        ST_RESEND: if (!suspend_xmission) state <= ST_SOP;
        default: state <= ST_IDLE;
      endcase

      // Abandon: mid-packet truncates through EOP and the gap, otherwise straight to IDLE
      if (uerr_take) begin
        tx_abort <= 1'b1;
        case (state)
          ST_SOP, ST_TYPE, ST_PAYLOAD, ST_CRC: begin
            state <= ST_EOP;
            drop  <= 1'b1;
          end
          ST_EOP, ST_GAP: drop  <= 1'b1;
          default:        state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/jtag_1149_d10_mstr_tx_pkt_gen.md
# jtag_1149_d10_mstr_tx_pkt_gen

Master-side PEDDA transmit packet generator for the IEEE 1149.10 master. It accepts one scan request word at a time and frames it as SOP, type, payload, CRC and EOP characters for the 8b/10b encoder. It holds each packet until the master Rx controller reports the outcome, then retransmits on retry or timeout, or drops the packet on an unrecoverable error. It also suspends transmission at packet boundaries while the link partner has flow-controlled the master with XOFF.

## Interface
- DATA_WIDTH, 8, encoder character width
- SCAN_WIDTH, 32, scan request payload width (4 bytes)
- CRC_WIDTH, 32, CRC width
- IDLE_GAP, 4, minimum K28.5 IDLE characters after every EOP (valid range 1..15)
- MAX_TIMEOUT, 3, retransmissions allowed on timeout before declaring failure
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- scan_req_data  in  SCAN_WIDTH  payload, byte 0 = bits [7:0]
- scan_req_be  in  4  payload byte enables
- scan_req_type  in  DATA_WIDTH  packet type byte
- scan_req_vld  in  1  request valid
- scan_req_rdy  out  1  request accepted when vld&&rdy
- encoder_data  out  DATA_WIDTH  character to the 8b/10b encoder (registered)
- encoder_k_in  out  1  1 = control character (registered)
- crc_data_valid  out  1  CRC input beat strobe
- crc_data_be  out  4  CRC byte enables
- crc_data_eop  out  1  last CRC beat
- crc_data_in  out  CRC_WIDTH  CRC input word
- crc_result  in  CRC_WIDTH  CRC result, valid the cycle after crc_data_eop
- send_pkt  out  1  one-cycle pulse when EOP is driven
- send_pkt_type  out  DATA_WIDTH  type of the packet just sent (held)
- rd_nxt_instr  in  1  Rx: response good, packet released
- instr_retry  in  1  Rx: resend the current packet
- suspend_xmission  in  1  Rx: XOFF active
- unrecoverable_error  in  1  Rx: abandon the current packet
- scan_rsp_time_out  in  1  Rx: response timeout pulse
- tx_abort  out  1  one-cycle pulse when a packet is dropped
- tx_timeout_error  out  1  sticky; cleared by rst or by the next accepted request

## Operation
- Characters:
  - SOP = K28.1 (0x3C, k=1)
  - EOP = K29.7 (0xFD, k=1)
  - IDLE = K28.5 (0xBC, k=1)
  - type, payload and CRC bytes are sent with k=0
- Packet order: SOP, type, N payload bytes (LSB first), 4 CRC bytes (crc_result[7:0] first), EOP.
- Payload length N = index of the highest set bit of scan_req_be, plus 1. For be=0, N=0. Example: be=4'b0100 gives N=3.
- Request capture:
  - On a handshake, latch data, be, type and N into the packet buffer.
  - Clear the timeout counter and tx_timeout_error.
- States:
  - IDLE: drive IDLE; scan_req_rdy=1 only here and only when suspend_xmission=0; handshake -> SOP.
  - SOP: drive SOP; one CRC beat (crc_data_in=buffered data, crc_data_be=buffered be, valid=eop=1); -> TYPE.
  - TYPE: drive type; latch crc_result; -> PAYLOAD if N>0, else -> CRC.
  - PAYLOAD: N cycles; -> CRC.
  - CRC: 4 cycles; -> EOP.
  - EOP: drive EOP; send_pkt=1; send_pkt_type<=type; -> GAP.
  - GAP: drive IDLE for IDLE_GAP cycles; -> WAIT_RSP.
  - WAIT_RSP: drive IDLE; events below.
  - RESEND: drive IDLE; wait until suspend_xmission=0, then -> SOP.
- WAIT_RSP events, by priority (highest first):
  1. unrecoverable_error: tx_abort pulse; -> IDLE.
  2. rd_nxt_instr: -> IDLE.
  3. instr_retry: -> RESEND.
  4. scan_rsp_time_out: if the timeout count is below MAX_TIMEOUT, increment it and -> RESEND. Otherwise set tx_timeout_error, pulse tx_abort and -> IDLE.
- Events outside WAIT_RSP are ignored. The exception is unrecoverable_error, which is honoured in any state except IDLE. Mid-packet it forces EOP next cycle (truncated packet, no send_pkt), then GAP, then IDLE, with a tx_abort pulse.
- Suspend is sampled only in IDLE and RESEND. A packet already started always completes.

## Timing
- Handshake in cycle T: state SOP in T+1, and SOP appears on encoder_data in T+2. Outputs lag the state by one register stage.
- Packet length is N+7 characters. Back-to-back spacing from EOP to the next SOP is at least IDLE_GAP+2 cycles.
- The CRC beat is issued in the SOP state cycle. crc_result is sampled exactly one cycle later.
- Reset values:
  - encoder_data=0xBC, encoder_k_in=1
  - scan_req_rdy=0, send_pkt=0, send_pkt_type=0
  - all crc_* outputs 0, tx_abort=0, tx_timeout_error=0
  - state IDLE, counters 0
- Reset mid-packet: output is IDLE the cycle after rst is sampled; the buffered packet is discarded.
- If rd_nxt_instr and instr_retry arrive together, rd_nxt_instr wins (release).

## Test plan
- Single request: data=0xA1B2C3D4, be=4'hF, type=0x05, crc_result=0x11223344. Encoder sees 3C, 05, D4, C3, B2, A1, 44, 33, 22, 11, FD (k=1 on first/last), then 4×BC. send_pkt pulses with send_pkt_type=0x05.
- be=4'b0010 and be=4'b0000: 2 payload bytes (D4, C3) and 0 payload bytes. CRC beat carries be as given. Packet lengths are 9 and 7.
- instr_retry in WAIT_RSP: identical packet resent after RESEND. scan_req_rdy stays 0 until rd_nxt_instr.
- Four scan_rsp_time_out pulses: three resends, then tx_timeout_error=1 and tx_abort pulse. The next handshake clears the flag.
- suspend_xmission=1 before the request: rdy=0 and only BC is driven. Raising suspend mid-packet does not stop the packet. A retry under suspend waits in RESEND.
- unrecoverable_error during payload byte 1: EOP next cycle, no send_pkt, tx_abort pulse, return to IDLE. rst asserted mid-packet: BC on the next cycle and all outputs at reset values.
